// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and helpers for the serial chunk adder controller.
// Optional signed-overflow flag is enabled with SERIAL_CHUNK_ADDER_OVF_EN.
package serial_chunk_adder_pkg;

    localparam int CW_DEFAULT = 12;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Chunk index width: clog2 of the chunk count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_ctrl.sv
// Slices a wide operand pair into CW-bit chunks for an external ripple adder and reassembles the sum.
// Define SERIAL_CHUNK_ADDER_OVF_EN to add the registered signed-overflow output out_ovf.
module serial_chunk_adder_ctrl
    import serial_chunk_adder_pkg::*;
#(
    parameter int CW       = CW_DEFAULT,
    parameter int N_CHUNKS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CW*N_CHUNKS-1:0] in_a,
    input  logic [CW*N_CHUNKS-1:0] in_b,
    input  logic                   in_ci,
    output logic [CW-1:0]          add_a,
    output logic [CW-1:0]          add_b,
    output logic                   add_ci,
    input  logic [CW-1:0]          add_sum,
    input  logic                   add_co,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW*N_CHUNKS-1:0] out_sum,
    output logic                   out_co
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    ,
    output logic                   out_ovf
`endif
);

    localparam int W  = CW * N_CHUNKS;
    localparam int IW = idx_width(N_CHUNKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CHUNKS - 1);

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic [IW-1:0]   idx;
    logic            ready_en;
    logic            accept;
    logic            run_last;

    // ready_en keeps in_ready low while reset is held and opens it on the first edge after release.
    assign accept   = (state == IDLE) && in_valid && ready_en;
    assign run_last = (state == RUN) && (idx == LAST_IDX);
    assign out_sum  = sum_r;
    assign out_co   = carry_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_ci     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ready_en;
                if (accept) state_next = RUN;
            end
            RUN: begin
                add_a  = a_r[int'(idx)*CW +: CW];
                add_b  = b_r[int'(idx)*CW +: CW];
                add_ci = carry_r;
                if (run_last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The adder is combinational, so each RUN edge captures the chunk sum and ripples its carry on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            ready_en <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
            out_ovf  <= 1'b0;
`endif
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                a_r     <= in_a;
                b_r     <= in_b;
                carry_r <= in_ci;
                idx     <= '0;
            end else if (state == RUN) begin
                sum_r[int'(idx)*CW +: CW] <= add_sum;
                carry_r                   <= add_co;
                if (!run_last) idx <= idx + 1'b1;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
                if (run_last) begin
                    out_ovf <= (a_r[W-1] == b_r[W-1]) && (add_sum[CW-1] != a_r[W-1]);
                end
`endif
            end
        end
    end

endmodule
